// File: rtl/sparse_tok_pkg.sv
// Shared sparse-stream token encoding: a control flag at bit DW, a
// stop/done tag in bits [9:8] and a stop level in bits [7:0].
package sparse_tok_pkg;

  localparam int TAG_HI = 9;
  localparam int TAG_LO = 8;

  localparam logic [1:0] TAG_STOP = 2'b00;
  localparam logic [1:0] TAG_DONE = 2'b01;

  // Canonical done token for the 16-bit payload build.
  localparam logic [16:0] DONE_TOKEN = 17'h10100;

  typedef enum logic {
    ST_EMIT,
    ST_FINAL
  } pad_state_e;

endpackage

// File: rtl/crd_pad_oreg.sv
// One-entry output register for a pair of streams that share one valid.
// The entry fires only when both consumers are ready, so neither sink can lose or duplicate a token.
module crd_pad_oreg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         flush,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_a,
  input  logic [W-1:0] load_b,
  input  logic         a_ready,
  input  logic         b_ready,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         a_valid,
  output logic         b_valid,
  output logic         can_load
);

  logic vld_q;
  logic fire;

  // Valid is masked while disabled so a frozen entry cannot be taken twice.
  assign fire     = vld_q & a_ready & b_ready & en;
  assign can_load = ~vld_q | fire;
  assign a_valid  = vld_q & en;
  assign b_valid  = vld_q & en;

  always_ff @(posedge clk) begin
    if (flush) begin
      vld_q <= 1'b0;
      a     <= '0;
      b     <= '0;
    end else if (en) begin
      if (load) begin
        vld_q <= 1'b1;
        a     <= load_a;
        b     <= load_b;
      end else if (fire) begin
        vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/crd_pad.sv
// Expands a compressed sorted coordinate/value stream into a dense fiber of length dim_size,
// padding missing coordinates with zero values; one output token per cycle, one-cycle latency.
module crd_pad
  import sparse_tok_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          flush,
  input  logic          clk_en,
  input  logic          tile_en,
  input  logic [DW-1:0] dim_size,
  input  logic [DW:0]   crd_in,
  input  logic          crd_in_valid,
  output logic          crd_in_ready,
  input  logic [DW:0]   val_in,
  input  logic          val_in_valid,
  output logic          val_in_ready,
  output logic [DW:0]   crd_out,
  output logic          crd_out_valid,
  input  logic          crd_out_ready,
  output logic [DW:0]   val_out,
  output logic          val_out_valid,
  input  logic          val_out_ready,
  output logic          err
);

  localparam logic [DW:0] STOP0    = {1'b1, DW'(0)};
  localparam logic [DW:0] DONE_TOK = {1'b1, DW'(DONE_TOKEN[15:0])};

  pad_state_e    state, state_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic          err_q;

  logic          en, can_load, load, pop, pad, do_final, set_err, clr_err;
  logic [DW:0]   crd_d, val_d;
  logic          head_vld, is_ctl;
  logic [DW-1:0] c;
  logic [1:0]    tag;

  assign en       = clk_en & tile_en & ~flush;
  assign head_vld = crd_in_valid & val_in_valid;
  assign is_ctl   = crd_in[DW];
  assign c        = crd_in[DW-1:0];
  assign tag      = crd_in[TAG_HI:TAG_LO];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    pop       = 1'b0;
    pad       = 1'b0;
    do_final  = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    crd_d     = '0;
    val_d     = '0;

    if (en && can_load) begin
      if (state == ST_FINAL) begin
        do_final = 1'b1;
      end else if (head_vld) begin
        if (!is_ctl) begin
          if (c >= dim_size || c < cnt) begin
            pop     = 1'b1;
            set_err = 1'b1;
          end else if (cnt < c) begin
            pad = 1'b1;
          end else begin
            load    = 1'b1;
            pop     = 1'b1;
            crd_d   = {1'b0, c};
            val_d   = val_in;
            cnt_nxt = cnt + 1'b1;
          end
        end else if (tag == TAG_STOP) begin
          if (cnt < dim_size) begin
            pad = 1'b1;
          end else begin
            load    = 1'b1;
            pop     = 1'b1;
            crd_d   = crd_in;
            val_d   = crd_in;
            cnt_nxt = '0;
          end
        end else if (tag == TAG_DONE) begin
          if (cnt == '0) begin
            load    = 1'b1;
            pop     = 1'b1;
            clr_err = 1'b1;
            crd_d   = DONE_TOK;
            val_d   = DONE_TOK;
          end else begin
            do_final = 1'b1;
          end
        end else begin
          pop     = 1'b1;
          set_err = 1'b1;
        end
      end

      // Done arrived mid-fiber: finish the fiber and close it with a level-0 stop
      // before the done itself is allowed through.
      if (do_final) begin
        if (cnt < dim_size) begin
          pad       = 1'b1;
          state_nxt = ST_FINAL;
        end else begin
          load      = 1'b1;
          crd_d     = STOP0;
          val_d     = STOP0;
          cnt_nxt   = '0;
          state_nxt = ST_EMIT;
        end
      end

      if (pad) begin
        load    = 1'b1;
        crd_d   = {1'b0, cnt};
        val_d   = '0;
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state <= ST_EMIT;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (en) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (set_err) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

  assign crd_in_ready = pop;
  assign val_in_ready = pop;
  assign err          = err_q;

  crd_pad_oreg #(
    .W (DW + 1)
  ) u_oreg (
    .clk      (clk),
    .flush    (flush),
    .en       (en),
    .load     (load),
    .load_a   (crd_d),
    .load_b   (val_d),
    .a_ready  (crd_out_ready),
    .b_ready  (val_out_ready),
    .a        (crd_out),
    .b        (val_out),
    .a_valid  (crd_out_valid),
    .b_valid  (val_out_valid),
    .can_load (can_load)
  );

endmodule

// File: tb/tb_crd_pad.sv
// Directed bench for crd_pad: hand-written token streams with expected dense output,
// plus randomised backpressure and input gaps on the same streams.
module tb_crd_pad;
  import sparse_tok_pkg::*;

  typedef logic [16:0] tok_t;

  localparam tok_t S0 = 17'h10000;
  localparam tok_t S1 = 17'h10001;
  localparam tok_t DN = DONE_TOKEN;

  logic        clk = 1'b0;
  logic        flush;
  logic        clk_en;
  logic        tile_en;
  logic [15:0] dim_size;
  tok_t        crd_in;
  logic        crd_in_valid;
  logic        crd_in_ready;
  tok_t        val_in;
  logic        val_in_valid;
  logic        val_in_ready;
  tok_t        crd_out;
  logic        crd_out_valid;
  logic        crd_out_ready;
  tok_t        val_out;
  logic        val_out_valid;
  logic        val_out_ready;
  logic        err;

  int checks = 0;
  int errors = 0;

  tok_t ci_q[$];
  tok_t vi_q[$];
  tok_t ec_q[$];
  tok_t ev_q[$];

  int r_first;
  int r_last;
  bit r_err_seen;
  bit r_err_end;

  always #5 clk = ~clk;

  crd_pad #(.DW(16)) dut (
    .clk           (clk),
    .flush         (flush),
    .clk_en        (clk_en),
    .tile_en       (tile_en),
    .dim_size      (dim_size),
    .crd_in        (crd_in),
    .crd_in_valid  (crd_in_valid),
    .crd_in_ready  (crd_in_ready),
    .val_in        (val_in),
    .val_in_valid  (val_in_valid),
    .val_in_ready  (val_in_ready),
    .crd_out       (crd_out),
    .crd_out_valid (crd_out_valid),
    .crd_out_ready (crd_out_ready),
    .val_out       (val_out),
    .val_out_valid (val_out_valid),
    .val_out_ready (val_out_ready),
    .err           (err)
  );

  function automatic tok_t d(input int x);
    logic [31:0] v;
    v = x;
    return {1'b0, v[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Streams ci_q/vi_q into the DUT and checks the output against ec_q/ev_q.
  // max_out < 0 consumes the whole expected sequence and then checks for strays.
  task automatic run(input logic [15:0] n, input bit rnd, input int max_out, input string name);
    int i, j, cyc, lim, extra;
    i = 0; j = 0; cyc = 0; extra = 0;
    r_first = -1; r_last = -1; r_err_seen = 1'b0; r_err_end = 1'b0;
    dim_size = n;
    lim = (max_out < 0) ? ec_q.size() : max_out;
    while (j < lim && cyc < 400) begin
      @(negedge clk);
      if (i < ci_q.size() && (!rnd || $urandom_range(1, 0) == 1)) begin
        crd_in_valid = 1'b1;
        val_in_valid = 1'b1;
        crd_in       = ci_q[i];
        val_in       = vi_q[i];
      end else begin
        crd_in_valid = 1'b0;
        val_in_valid = 1'b0;
      end
      crd_out_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      val_out_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      #1;
      r_err_seen |= err;
      if (crd_out_valid !== val_out_valid)
        chk({name, "_valid_pair"}, {31'd0, crd_out_valid}, {31'd0, val_out_valid});
      if (crd_in_ready === 1'b1) i++;
      if (crd_out_valid && crd_out_ready && val_out_ready) begin
        chk($sformatf("%s_crd%0d", name, j), {15'd0, crd_out}, {15'd0, ec_q[j]});
        chk($sformatf("%s_val%0d", name, j), {15'd0, val_out}, {15'd0, ev_q[j]});
        if (r_first < 0) r_first = cyc;
        r_last    = cyc;
        r_err_end = err;
        j++;
      end
      cyc++;
    end
    chk({name, "_count"}, j, lim);
    if (max_out < 0) begin
      crd_in_valid  = 1'b0;
      val_in_valid  = 1'b0;
      crd_out_ready = 1'b1;
      val_out_ready = 1'b1;
      repeat (3) begin
        @(negedge clk);
        #1;
        if (crd_out_valid || val_out_valid) extra++;
      end
      chk({name, "_no_extra"}, extra, 0);
    end
  endtask

  initial begin
    flush         = 1'b1;
    clk_en        = 1'b1;
    tile_en       = 1'b1;
    dim_size      = 16'd4;
    crd_in        = d(0);
    val_in        = d(0);
    crd_in_valid  = 1'b1;
    val_in_valid  = 1'b1;
    crd_out_ready = 1'b1;
    val_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_crd_valid", {31'd0, crd_out_valid}, 0);
    chk("rst_val_valid", {31'd0, val_out_valid}, 0);
    chk("rst_crd_out", {15'd0, crd_out}, 0);
    chk("rst_val_out", {15'd0, val_out}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_crd_ready", {31'd0, crd_in_ready}, 0);
    chk("rst_val_ready", {31'd0, val_in_ready}, 0);
    @(negedge clk);
    flush        = 1'b0;
    crd_in_valid = 1'b0;
    val_in_valid = 1'b0;

    // N=4, sparse {1,3}: padded fiber, six back-to-back output cycles
    ci_q = '{d(1), d(3), S0, DN};
    vi_q = '{d(7), d(9), S0, DN};
    ec_q = '{d(0), d(1), d(2), d(3), S0, DN};
    ev_q = '{d(0), d(7), d(0), d(9), S0, DN};
    run(16'd4, 1'b0, -1, "basic");
    chk("basic_first_cycle", r_first, 1);
    chk("basic_span", r_last - r_first + 1, 6);
    chk("basic_no_err", {31'd0, r_err_seen}, 0);

    // Two empty fibers
    ci_q = '{S0, S1, DN};
    vi_q = '{S0, S1, DN};
    ec_q = '{d(0), d(1), d(2), S0, d(0), d(1), d(2), S1, DN};
    ev_q = '{d(0), d(0), d(0), S0, d(0), d(0), d(0), S1, DN};
    run(16'd3, 1'b0, -1, "empty");

    // Same sparse stream under random backpressure and input gaps
    ci_q = '{d(1), d(3), S0, DN};
    vi_q = '{d(7), d(9), S0, DN};
    ec_q = '{d(0), d(1), d(2), d(3), S0, DN};
    ev_q = '{d(0), d(7), d(0), d(9), S0, DN};
    run(16'd4, 1'b1, -1, "rand_a");
    run(16'd4, 1'b1, -1, "rand_b");

    // Out-of-order coordinate: dropped and flagged, cleared by done
    ci_q = '{d(1), d(0), S0, DN};
    vi_q = '{d(17), d(34), S0, DN};
    ec_q = '{d(0), d(1), S0, DN};
    ev_q = '{d(0), d(17), S0, DN};
    run(16'd2, 1'b0, -1, "order");
    chk("order_err_set", {31'd0, r_err_seen}, 1);
    chk("order_err_clr", {31'd0, r_err_end}, 0);

    // Done mid-fiber: pad to N, then a level-0 stop, then done
    ci_q = '{d(1), DN};
    vi_q = '{d(8), DN};
    ec_q = '{d(0), d(1), d(2), S0, DN};
    ev_q = '{d(0), d(8), d(0), S0, DN};
    run(16'd3, 1'b0, -1, "final");

    // Flush mid-fiber after two outputs, with err already set
    ci_q = '{d(0), d(0), d(3), S0, DN};
    vi_q = '{d(1), d(2), d(3), S0, DN};
    ec_q = '{d(0), d(1)};
    ev_q = '{d(1), d(0)};
    run(16'd4, 1'b0, 2, "pre_flush");
    chk("pre_flush_err", {31'd0, err}, 1);
    @(negedge clk);
    flush         = 1'b1;
    crd_in_valid  = 1'b0;
    val_in_valid  = 1'b0;
    crd_out_ready = 1'b0;
    val_out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("flush_crd_valid", {31'd0, crd_out_valid}, 0);
    chk("flush_val_valid", {31'd0, val_out_valid}, 0);
    chk("flush_crd_out", {15'd0, crd_out}, 0);
    chk("flush_val_out", {15'd0, val_out}, 0);
    chk("flush_err", {31'd0, err}, 0);
    chk("flush_ready", {31'd0, crd_in_ready}, 0);
    @(negedge clk);
    flush = 1'b0;
    ci_q = '{d(2), S0, DN};
    vi_q = '{d(85), S0, DN};
    ec_q = '{d(0), d(1), d(2), d(3), S0, DN};
    ev_q = '{d(0), d(0), d(85), d(0), S0, DN};
    run(16'd4, 1'b0, -1, "post_flush");

    // N=0: stops pass straight through; any data is an error
    ci_q = '{S0, DN};
    vi_q = '{S0, DN};
    ec_q = '{S0, DN};
    ev_q = '{S0, DN};
    run(16'd0, 1'b0, -1, "n0_clean");
    chk("n0_clean_err", {31'd0, r_err_seen}, 0);
    ci_q = '{d(5), S0, DN};
    vi_q = '{d(1), S0, DN};
    ec_q = '{S0, DN};
    ev_q = '{S0, DN};
    run(16'd0, 1'b0, -1, "n0_data");
    chk("n0_data_err_set", {31'd0, r_err_seen}, 1);
    chk("n0_data_err_clr", {31'd0, r_err_end}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
